// File: rtl/backward_pipe_if.sv
// Handshake bundle for backward_pipe: upstream (_f) and downstream (_b) sides plus status.
// master is the environment around the stage, slave is the stage itself.
interface backward_pipe_if #(
  parameter int L  = 8,
  parameter int CW = 16
);
  logic          ready_f;
  logic          valid_f;
  logic [L-1:0]  data_f;
  logic          ready_b;
  logic          valid_b;
  logic [L-1:0]  data_b;
  logic          skid_full;
  logic [CW-1:0] beat_cnt;

  modport master (
    input  ready_f, valid_b, data_b, skid_full, beat_cnt,
    output valid_f, data_f, ready_b
  );

  modport slave (
    input  valid_f, data_f, ready_b,
    output ready_f, valid_b, data_b, skid_full, beat_cnt
  );
endinterface

// File: rtl/backward_pipe.sv
// Backward-registered pipe stage with one-beat skid; zero-cycle pass-through when empty.
// ready_f is a flop, so a stall on ready_b reaches upstream one cycle late and the skid absorbs that beat.
module backward_pipe #(
  parameter int L  = 8,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  backward_pipe_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e        state_q, state_d;
  logic [L-1:0]  skid_q, skid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_f_q, ready_f_d;
  logic          valid_b;
  logic [L-1:0]  data_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      skid_q    <= '0;
      cnt_q     <= '0;
      ready_f_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skid_q    <= skid_d;
      cnt_q     <= cnt_d;
      ready_f_q <= ready_f_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    valid_b = bus.valid_f;
    data_b  = bus.data_f;
    case (state_q)
      EMPTY: begin
        // Downstream stalled while a beat is offered: park it in the skid.
        if (bus.valid_f && !bus.ready_b) begin
          state_d = FULL;
          skid_d  = bus.data_f;
        end
      end
      FULL: begin
        valid_b = 1'b1;
        data_b  = skid_q;
        if (bus.ready_b) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (valid_b && bus.ready_b) begin
      cnt_d = cnt_q + CW'(1);
    end
    // Registered from next state only, so ready_b never reaches ready_f within a cycle.
    ready_f_d = (state_d == EMPTY);
  end

  assign bus.ready_f   = ready_f_q;
  assign bus.valid_b   = valid_b;
  assign bus.data_b    = data_b;
  assign bus.skid_full = (state_q == FULL);
  assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_backward_pipe.sv
// Scoreboard bench for backward_pipe: driver pushes accepted beats, negedge monitor pops and compares.
module tb_backward_pipe;
  localparam int L  = 8;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  backward_pipe_if #(.L(L), .CW(CW)) bus ();
  backward_pipe #(.L(L), .CW(CW)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  logic [L-1:0]  exp_q[$];
  int            n_chk = 0;
  int            n_err = 0;
  bit            m_full = 1'b0;
  bit            m_rdy  = 1'b0;
  logic [CW-1:0] m_cnt  = '0;
  int            n_acc  = 0;
  int            n_del  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, starting just after a rising edge.
  task automatic cyc(input bit vf, input logic [L-1:0] df, input bit rb);
    bus.valid_f = vf;
    bus.data_f  = df;
    bus.ready_b = rb;
    if (vf && m_rdy && !m_full) begin
      exp_q.push_back(df);
      n_acc++;
    end
    @(posedge clk);
    if (m_full) m_full = !rb;
    else        m_full = vf && m_rdy && !rb;
    m_rdy = !m_full;
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_f", {31'd0, bus.ready_f}, {31'd0, m_rdy});
      check("skid_full", {31'd0, bus.skid_full}, {31'd0, m_full});
      check("beat_cnt", 32'(bus.beat_cnt), 32'(m_cnt));
      if (m_full) begin
        check("valid_b_full", {31'd0, bus.valid_b}, 32'd1);
        if (exp_q.size() > 0) check("skid_data", 32'(bus.data_b), 32'(exp_q[0]));
      end else begin
        check("valid_b_pass", {31'd0, bus.valid_b}, {31'd0, bus.valid_f});
        check("data_b_pass", 32'(bus.data_b), 32'(bus.data_f));
      end
      if (bus.valid_b && bus.ready_b) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL out_unexpected: got beat %0h, expected no beat at %0t", bus.data_b, $time);
        end else begin
          check("out_data", 32'(bus.data_b), 32'(exp_q.pop_front()));
        end
        m_cnt++;
        n_del++;
      end
    end
  end

  initial begin
    bus.valid_f = 1'b0;
    bus.data_f  = '0;
    bus.ready_b = 1'b0;

    // Reset state
    #2;
    check("rst_ready_f", {31'd0, bus.ready_f}, 32'd0);
    check("rst_skid_full", {31'd0, bus.skid_full}, 32'd0);
    check("rst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    #20 rst_n = 1'b1;
    #1 check("rdy_before_edge", {31'd0, bus.ready_f}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check("rdy_first_edge", {31'd0, bus.ready_f}, 32'd1);

    // Pass-through
    cyc(1'b1, 8'h11, 1'b1);
    cyc(1'b1, 8'h22, 1'b1);
    cyc(1'b1, 8'h33, 1'b1);
    check("pass_cnt", 32'(bus.beat_cnt), 32'd3);
    check("pass_skid", {31'd0, bus.skid_full}, 32'd0);

    // Skid capture and hold
    cyc(1'b1, 8'hA5, 1'b0);
    bus.data_f = 8'h5A;
    #1;
    check("cap_skid_full", {31'd0, bus.skid_full}, 32'd1);
    check("cap_ready_f", {31'd0, bus.ready_f}, 32'd0);
    check("cap_valid_b", {31'd0, bus.valid_b}, 32'd1);
    check("cap_data_b", 32'(bus.data_b), 32'hA5);
    repeat (4) cyc(1'b1, 8'h5A, 1'b0);
    check("hold_data_b", 32'(bus.data_b), 32'hA5);

    // Drain
    cyc(1'b1, 8'h77, 1'b1);
    check("drain_cnt", 32'(bus.beat_cnt), 32'd4);
    check("drain_skid", {31'd0, bus.skid_full}, 32'd0);
    check("drain_ready_f", {31'd0, bus.ready_f}, 32'd1);
    bus.data_f = 8'h66;
    #1 check("drain_follow", 32'(bus.data_b), 32'h66);
    cyc(1'b1, 8'h66, 1'b1);
    check("drain_cnt2", 32'(bus.beat_cnt), 32'd5);

    // Reset while holding a beat: the parked beat must vanish
    cyc(1'b1, 8'h3C, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_full = 1'b0;
    m_rdy  = 1'b0;
    m_cnt  = '0;
    n_del  = 0;
    bus.valid_f = 1'b0;
    bus.ready_b = 1'b1;
    #1;
    check("arst_skid_full", {31'd0, bus.skid_full}, 32'd0);
    check("arst_ready_f", {31'd0, bus.ready_f}, 32'd0);
    check("arst_beat_cnt", 32'(bus.beat_cnt), 32'd0);
    check("arst_valid_b", {31'd0, bus.valid_b}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("arst_rdy_before_edge", {31'd0, bus.ready_f}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    check("arst_rdy_first_edge", {31'd0, bus.ready_f}, 32'd1);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 8'(i + 1), 1'b1);
      if (i == 14) check("wrap_15", 32'(bus.beat_cnt), 32'd15);
      if (i == 15) check("wrap_16", 32'(bus.beat_cnt), 32'd0);
      if (i == 16) check("wrap_17", 32'(bus.beat_cnt), 32'd1);
    end

    // Random stalls on both sides
    n_acc = 0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    end
    if (n_acc < 1000) begin
      n_chk++;
      n_err++;
      $display("FAIL rand_budget: got %0d accepted beats, expected 1000", n_acc);
    end
    repeat (4) cyc(1'b0, 8'h00, 1'b1);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rand_cnt_mod", 32'(bus.beat_cnt), 32'(n_del % 16));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
